// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer around a single 1-bit ULA slice: one bit per clock, LSB first.
// Optional ULA_SERIAL_OVF_EN adds an ovf output and an overflow-corrected SLT.
module ula_serial_ctrl #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   controle,
   input  logic [N-1:0] op_a,
   input  logic [N-1:0] op_b,
   output logic         sl_a,
   output logic         sl_b,
   output logic         sl_cin,
   output logic         sl_addsub,
   output logic         sl_less,
   output logic [2:0]   sl_controle,
   input  logic         sl_saida,
   input  logic         sl_cout,
   input  logic         sl_set,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] resultado,
`ifdef ULA_SERIAL_OVF_EN
   output logic         ovf,
`endif
   output logic         zero
);

   localparam int CW = $clog2(N);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_RSV = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [N-1:0]    a_reg;
   logic [N-1:0]    b_reg;
   logic [2:0]      ctrl_reg;
   logic [CW-1:0]   cnt;
   logic            carry_reg;
   logic [N-1:0]    res_bits;

   logic            run;
   logic            last_bit;
   logic            sign_bit;
   logic [N-1:0]    res_next;
   logic [N-1:0]    res_final;

   assign run      = (state == RUN);
   assign last_bit = (cnt == CW'(N - 1));

   // Slice is held quiescent (all zeros) outside RUN.
   assign sl_a        = run & a_reg[cnt];
   assign sl_b        = run & b_reg[cnt];
   assign sl_addsub   = run & ctrl_reg[2] & ctrl_reg[1];
   assign sl_cin      = run & carry_reg;
   assign sl_less     = 1'b0;
   assign sl_controle = !run ? 3'b000 : (ctrl_reg == OP_SLT) ? OP_SUB : ctrl_reg;

`ifdef ULA_SERIAL_OVF_EN
   logic ovf_bit;
   // carry_reg holds the carry into the MSB during the last RUN cycle.
   assign ovf_bit  = carry_reg ^ sl_cout;
   assign sign_bit = sl_set ^ ovf_bit;
`else
   assign sign_bit = sl_set;
`endif

   always_comb begin
      res_next      = res_bits;
      res_next[cnt] = sl_saida;
      if (ctrl_reg == OP_SLT) begin
         res_final = {{(N-1){1'b0}}, sign_bit};
      end else begin
         res_final = res_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         ctrl_reg  <= 3'b000;
         cnt       <= '0;
         carry_reg <= 1'b0;
         res_bits  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         resultado <= '0;
         zero      <= 1'b1;
`ifdef ULA_SERIAL_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  ctrl_reg  <= controle;
                  cnt       <= '0;
                  carry_reg <= controle[2] & controle[1];
                  res_bits  <= '0;
                  busy      <= 1'b1;
                  if (controle == OP_RSV) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     resultado <= '0;
                     zero      <= 1'b1;
`ifdef ULA_SERIAL_OVF_EN
                     ovf       <= 1'b0;
`endif
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               carry_reg <= sl_cout;
               res_bits  <= res_next;
               cnt       <= cnt + CW'(1);
               if (last_bit) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  resultado <= res_final;
                  zero      <= (res_final == '0);
`ifdef ULA_SERIAL_OVF_EN
                  ovf       <= ((ctrl_reg == OP_ADD) || (ctrl_reg == OP_SUB)) ? ovf_bit : 1'b0;
`endif
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Self-checking bench for ula_serial_ctrl (N=8) with a behavioural 1-bit slice attached.
// Honours ULA_SERIAL_OVF_EN when defined.
module tb_ula_serial_ctrl;

   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [2:0]   controle;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         sl_a, sl_b, sl_cin, sl_addsub, sl_less;
   logic [2:0]   sl_controle;
   logic         sl_saida, sl_cout, sl_set;
   logic         busy, done, zero;
   logic [N-1:0] resultado;
`ifdef ULA_SERIAL_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;
   logic [N-1:0] prev_res;

   ula_serial_ctrl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .controle(controle),
      .op_a(op_a), .op_b(op_b),
      .sl_a(sl_a), .sl_b(sl_b), .sl_cin(sl_cin), .sl_addsub(sl_addsub),
      .sl_less(sl_less), .sl_controle(sl_controle),
      .sl_saida(sl_saida), .sl_cout(sl_cout), .sl_set(sl_set),
      .busy(busy), .done(done), .resultado(resultado),
`ifdef ULA_SERIAL_OVF_EN
      .ovf(ovf),
`endif
      .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Classic MIPS 1-bit ALU slice.
   logic bx, sum;
   always_comb begin
      bx       = sl_b ^ sl_addsub;
      sum      = sl_a ^ bx ^ sl_cin;
      sl_cout  = (sl_a & bx) | (sl_a & sl_cin) | (bx & sl_cin);
      sl_set   = sum;
      sl_saida = 1'b0;
      case (sl_controle)
         3'b000:         sl_saida = sl_a & sl_b;
         3'b001:         sl_saida = sl_a | sl_b;
         3'b010, 3'b110: sl_saida = sum;
         3'b011:         sl_saida = ~(sl_a | sl_b);
         3'b101:         sl_saida = sl_a ^ sl_b;
         3'b111:         sl_saida = sl_less;
         default:        sl_saida = 1'b0;
      endcase
   end

   function automatic logic [N-1:0] ref_result(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] d;
      d = a - b;
      case (c)
         3'b000: return a & b;
         3'b001: return a | b;
         3'b010: return a + b;
         3'b011: return ~(a | b);
         3'b101: return a ^ b;
         3'b110: return d;
`ifdef ULA_SERIAL_OVF_EN
         3'b111: return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
`else
         3'b111: return {{(N-1){1'b0}}, d[N-1]};
`endif
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (c == 3'b010)      r = sa + sb;
      else if (c == 3'b110) r = sa - sb;
      else return 1'b0;
      return (r > (2**(N-1) - 1)) || (r < -(2**(N-1)));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation; with hold=1 start stays high through RUN/DONE (back-to-back).
   task automatic run_op(input logic [2:0] c, input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
      int lat;
      bit stable;
      logic [N-1:0] exp_r;
      exp_r = ref_result(c, a, b);
      if (busy) begin
         @(posedge clk); #1;
         chk("idle_after_done", {busy, done}, 2'b00);
      end
      controle = c; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      if (!hold) start = 1'b0;
      if (c != 3'b100) begin
         chk("bit0_slice", {sl_a, sl_b, sl_addsub, sl_cin, sl_less},
             {a[0], b[0], c[2] & c[1], c[2] & c[1], 1'b0});
      end
      stable = 1'b1;
      while (!done && lat < 40) begin
         if (resultado !== prev_res || busy !== 1'b1) stable = 1'b0;
         op_a = N'($urandom); op_b = N'($urandom); controle = 3'($urandom);
         if (!hold) start = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 64'(lat), (c == 3'b100) ? 64'd1 : 64'(N + 1));
      chk("stable_during_run", {63'd0, stable}, 64'd1);
      chk("resultado", 64'(resultado), 64'(exp_r));
      chk("zero", {63'd0, zero}, {63'd0, exp_r == '0});
      chk("done_state_quiet", {busy, sl_a, sl_b, sl_cin, sl_addsub, sl_less, sl_controle}, 9'b1_0000_0000);
`ifdef ULA_SERIAL_OVF_EN
      chk("ovf", {63'd0, ovf}, {63'd0, ref_ovf(c, a, b)});
`endif
      $display("op ctrl=%b a=%h b=%h -> resultado=%h zero=%b lat=%0d", c, a, b, resultado, zero, lat);
      prev_res = exp_r;
      if (!hold) begin
         start = 1'b0;
         @(posedge clk); #1;
         chk("done_one_cycle", {busy, done}, 2'b00);
      end
   endtask

   initial begin
      int k;
      rst_n = 1'b0; start = 1'b0; controle = 3'b000; op_a = '0; op_b = '0;
      prev_res = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, zero, resultado}, {3'b001, N'(0)});
      chk("reset_slice", {sl_a, sl_b, sl_cin, sl_addsub, sl_less, sl_controle}, 8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(3'b010, 8'h7F, 8'h01, 1'b0);
      run_op(3'b110, 8'h05, 8'h05, 1'b0);
      run_op(3'b111, 8'h03, 8'h05, 1'b0);
      run_op(3'b111, 8'h80, 8'h7F, 1'b0);
      run_op(3'b000, 8'hF0, 8'h3C, 1'b0);
      run_op(3'b001, 8'hF0, 8'h3C, 1'b0);
      run_op(3'b011, 8'hF0, 8'h3C, 1'b0);
      run_op(3'b101, 8'hF0, 8'h3C, 1'b0);
      run_op(3'b100, 8'hAA, 8'h55, 1'b0);

      // Back-to-back with start held high throughout.
      run_op(3'b010, 8'h12, 8'h34, 1'b1);
      run_op(3'b110, 8'h10, 8'h20, 1'b1);
      run_op(3'b100, 8'h01, 8'h02, 1'b1);
      run_op(3'b001, 8'h81, 8'h18, 1'b0);

      // Reset in RUN cycle 4.
      controle = 3'b010; op_a = 8'h55; op_b = 8'h22; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset_state", {busy, done, zero, resultado}, {3'b001, N'(0)});
      rst_n = 1'b1;
      k = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) k++;
      end
      chk("midreset_no_done", 64'(k), 64'd0);
      prev_res = '0;
      run_op(3'b010, 8'h55, 8'h22, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), N'($urandom), N'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      if (busy) begin
         start = 1'b0;
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
